// File: rtl/dla_cfg_regfile_if.sv
// Host register bus between the config initiator and the DLA register file.
// Latency: reads return one cycle after the strobe; writes take effect at the strobe edge.
// Backpressure: none; one write and one read may be issued every cycle.
interface dla_cfg_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] reg_addr_wr;
    logic [DATA_W-1:0] reg_data_wr;
    logic              reg_en_wr;
    logic [ADDR_W-1:0] reg_addr_rd;
    logic              reg_en_rd;
    logic [DATA_W-1:0] reg_data_rd;
    logic              reg_rd_valid;

    modport master (
        output reg_addr_wr, reg_data_wr, reg_en_wr, reg_addr_rd, reg_en_rd,
        input  reg_data_rd, reg_rd_valid
    );

    modport slave (
        input  reg_addr_wr, reg_data_wr, reg_en_wr, reg_addr_rd, reg_en_rd,
        output reg_data_rd, reg_rd_valid
    );
endinterface

// File: rtl/dla_cfg_regfile.sv
// DLA layer configuration register file: host decode, cfg outputs, sheet-gen start/busy/finish tracking.
// Latency: cfg outputs update the cycle after a write; read data/valid one cycle after reg_en_rd.
// Backpressure: none; illegal or rejected accesses are dropped and counted in a saturating err_cnt.
module dla_cfg_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ERR_W  = 8
) (
    input  logic                clock,
    input  logic                rst_n,
    dla_cfg_regfile_if.slave    bus,
    input  logic                sheet_gen_done,
    output logic                sheet_gen_start,
    output logic                cfg_busy,
    output logic [7:0]          cfg_kernel_size,
    output logic [7:0]          cfg_stride,
    output logic [7:0]          cfg_pad_size,
    output logic [7:0]          cfg_pool_size,
    output logic [15:0]         cfg_ifmap_length,
    output logic [31:0]         cfg_ifmap_size,
    output logic [31:0]         cfg_ofmap_size,
    output logic [63:0]         cfg_tile_length,
    output logic [63:0]         cfg_tile_height,
    output logic [31:0]         cfg_tile_number
);

    localparam int NCFG = 26;
    localparam logic [ADDR_W-1:0] A_INIT   = ADDR_W'(32'h1b);
    localparam logic [ADDR_W-1:0] A_START  = ADDR_W'(32'h1c);
    localparam logic [ADDR_W-1:0] A_FINISH = ADDR_W'(32'h1d);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h1e);
    localparam logic [ERR_W+1:0]  ERR_MAX  = {2'b00, {ERR_W{1'b1}}};

    logic [DATA_W-1:0] cfg_q [1:NCFG];
    logic              init_q, init_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              finish_q, finish_d;
    logic              pulse_q, pulse_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_vld_q, rd_vld_d;

    logic              wr_is_cfg, wr_cfg_ok, wr_cfg_err;
    logic              wr_init, init_set, init_err;
    logic              wr_start, start_rise, start_ok, start_err;
    logic              wr_bad, done_ok, done_err, rd_err;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_mux;
    logic [ERR_W+1:0]  err_sum;

    // Write/done decode; every decision uses pre-edge state so simultaneous events stay independent.
    always_comb begin
        wr_is_cfg  = bus.reg_en_wr && (bus.reg_addr_wr >= ADDR_W'(1)) && (bus.reg_addr_wr <= ADDR_W'(NCFG));
        // While REG_INIT holds the block, config writes vanish without counting as errors.
        wr_cfg_ok  = wr_is_cfg && !init_q && !busy_q;
        wr_cfg_err = wr_is_cfg && !init_q && busy_q;
        wr_init    = bus.reg_en_wr && (bus.reg_addr_wr == A_INIT);
        init_set   = wr_init && bus.reg_data_wr[0] && !busy_q;
        init_err   = wr_init && bus.reg_data_wr[0] && busy_q;
        wr_start   = bus.reg_en_wr && (bus.reg_addr_wr == A_START);
        start_rise = wr_start && bus.reg_data_wr[0] && !start_q;
        start_ok   = start_rise && !busy_q && !init_q;
        start_err  = start_rise && (busy_q || init_q);
        wr_bad     = bus.reg_en_wr && !wr_is_cfg && !wr_init && !wr_start;
        done_ok    = sheet_gen_done && busy_q;
        done_err   = sheet_gen_done && !busy_q;
    end

    // Read mux over config storage and the control/status words.
    always_comb begin
        rd_mux = '0;
        rd_hit = 1'b0;
        for (int i = 1; i <= NCFG; i++) begin
            if (bus.reg_addr_rd == ADDR_W'(i)) begin
                rd_mux = cfg_q[i];
                rd_hit = 1'b1;
            end
        end
        if (bus.reg_addr_rd == A_INIT) begin
            rd_mux = {{(DATA_W-1){1'b0}}, init_q};
            rd_hit = 1'b1;
        end
        if (bus.reg_addr_rd == A_START) begin
            rd_mux = {{(DATA_W-1){1'b0}}, start_q};
            rd_hit = 1'b1;
        end
        if (bus.reg_addr_rd == A_FINISH) begin
            rd_mux = {{(DATA_W-1){1'b0}}, finish_q};
            rd_hit = 1'b1;
        end
        if (bus.reg_addr_rd == A_STATUS) begin
            rd_mux = {{(DATA_W-16-ERR_W){1'b0}}, err_q, 6'b0, finish_q, busy_q};
            rd_hit = 1'b1;
        end
        rd_err = bus.reg_en_rd && !rd_hit;
    end

    // Next-state for control bits, error counter and read port.
    always_comb begin
        init_d = init_q;
        if (wr_init && !init_err) init_d = bus.reg_data_wr[0];

        // The stored start bit follows the host even when the start itself is rejected.
        start_d = wr_start ? bus.reg_data_wr[0] : start_q;

        busy_d = busy_q;
        if (start_ok)     busy_d = 1'b1;
        else if (done_ok) busy_d = 1'b0;

        finish_d = finish_q;
        if (start_ok || init_set) finish_d = 1'b0;
        else if (done_ok)         finish_d = 1'b1;

        pulse_d = start_ok;

        // At most one write error plus done and read errors can land in one cycle.
        err_sum = {2'b00, err_q}
                + (ERR_W+2)'(wr_cfg_err | init_err | start_err | wr_bad)
                + (ERR_W+2)'(done_err)
                + (ERR_W+2)'(rd_err);
        if (init_set)               err_d = '0;
        else if (err_sum > ERR_MAX) err_d = {ERR_W{1'b1}};
        else                        err_d = err_sum[ERR_W-1:0];

        rd_vld_d  = bus.reg_en_rd;
        rd_data_d = bus.reg_en_rd ? rd_mux : rd_data_q;
    end

    // Config storage: host writes when released and idle, bulk clear on accepted REG_INIT.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= NCFG; i++) cfg_q[i] <= '0;
        end else begin
            for (int i = 1; i <= NCFG; i++) begin
                if (init_set)
                    cfg_q[i] <= '0;
                else if (wr_cfg_ok && (bus.reg_addr_wr == ADDR_W'(i)))
                    cfg_q[i] <= bus.reg_data_wr;
            end
        end
    end

    // Control/status state and the registered read port.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            init_q    <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            pulse_q   <= 1'b0;
            err_q     <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            init_q    <= init_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
            pulse_q   <= pulse_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign bus.reg_data_rd  = rd_data_q;
    assign bus.reg_rd_valid = rd_vld_q;
    assign sheet_gen_start  = pulse_q;
    assign cfg_busy         = busy_q;

    assign cfg_kernel_size  = cfg_q[1][7:0];
    assign cfg_stride       = cfg_q[2][7:0];
    assign cfg_pad_size     = cfg_q[3][7:0];
    assign cfg_pool_size    = cfg_q[4][7:0];
    assign cfg_ifmap_length = cfg_q[7][15:0];
    assign cfg_ifmap_size   = cfg_q[8][31:0];
    assign cfg_ofmap_size   = cfg_q[9][31:0];
    assign cfg_tile_length  = {cfg_q[18][15:0], cfg_q[17][15:0], cfg_q[16][15:0], cfg_q[15][15:0]};
    assign cfg_tile_height  = {cfg_q[22][15:0], cfg_q[21][15:0], cfg_q[20][15:0], cfg_q[19][15:0]};
    assign cfg_tile_number  = {cfg_q[26][7:0], cfg_q[25][7:0], cfg_q[24][7:0], cfg_q[23][7:0]};

endmodule
